// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and constants for the PS/2 host transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INHIBIT = 2'd1,
    SEND    = 2'd2
  } ps2_tx_state_t;

  localparam int PS2_FRAME_EDGES = 11;
  localparam int PS2_TX_RETRIES  = 2;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx_if
// Brief    : Command handshake between a client and the PS/2 host transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;

  logic       start;
  logic [7:0] data_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic       ack_ok;

  modport master (
    output start,
    output data_in,
    input  ready,
    input  busy,
    input  done,
    input  ack_ok
  );

  modport slave (
    input  start,
    input  data_in,
    output ready,
    output busy,
    output done,
    output ack_ok
  );

endinterface
`default_nettype wire

// File: rtl/ps2_host_tx_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_sync
// Brief    : Two-flop synchronizer for one PS/2 line plus a falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
  input  wire  clk,
  input  wire  reset,
  input  wire  line_in,
  output logic line_sync,
  output logic line_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_fall;

  // Idle PS/2 lines float high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_meta <= line_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fall <= r_prev & ~r_sync;
    end
  end

  assign line_sync = r_sync;
  assign line_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device byte transmitter with request-to-send and ACK
//            check. Define PS2_HOST_TX_RETRY_EN to retry NACK/timeout frames.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  wire          clk,
  input  wire          reset,
  ps2_host_tx_if.slave cmd,
  input  wire          PS2_clk,
  input  wire          PS2_dat,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  import ps2_pkg::*;

  localparam int c_cnt_max = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_inh_start = c_cnt_w'(INHIBIT_CYCLES - 2);
  localparam logic [c_cnt_w-1:0] c_inh_last  = c_cnt_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         c_ack_edge  = 4'(PS2_FRAME_EDGES - 1);

  ps2_tx_state_t      r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]         r_bit, w_bit_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_par, w_par_nxt;
  logic               r_clk_oe, w_clk_oe_nxt;
  logic               r_dat_oe, w_dat_oe_nxt;
  logic               r_done, w_done_nxt;
  logic               r_ack, w_ack_nxt;
  logic               w_end;
  logic               w_end_ack;
  logic               w_can_retry;

  logic w_clk_sync_unused;
  logic w_clk_fall;
  logic w_dat_sync;
  logic w_dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (PS2_clk),
    .line_sync (w_clk_sync_unused),
    .line_fall (w_clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (PS2_dat),
    .line_sync (w_dat_sync),
    .line_fall (w_dat_fall_unused)
  );

`ifdef PS2_HOST_TX_RETRY_EN
  localparam logic [1:0] c_retries = 2'(PS2_TX_RETRIES);
  logic [1:0] r_tries, w_tries_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_tries <= 2'd0;
    else       r_tries <= w_tries_nxt;
  end

  assign w_can_retry = (r_tries != c_retries);
`else
  assign w_can_retry = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= 4'd0;
      r_data   <= 8'h00;
      r_par    <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_data   <= w_data_nxt;
      r_par    <= w_par_nxt;
      r_clk_oe <= w_clk_oe_nxt;
      r_dat_oe <= w_dat_oe_nxt;
      r_done   <= w_done_nxt;
      r_ack    <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_data_nxt   = r_data;
    w_par_nxt    = r_par;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_done_nxt   = 1'b0;
    w_ack_nxt    = r_ack;
    w_end        = 1'b0;
    w_end_ack    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    w_tries_nxt  = r_tries;
`endif

    unique case (r_state)
      IDLE: begin
        if (cmd.start) begin
          w_state_nxt  = INHIBIT;
          w_data_nxt   = cmd.data_in;
          w_par_nxt    = odd_parity(cmd.data_in);
          w_cnt_nxt    = '0;
          w_clk_oe_nxt = 1'b1;
          w_dat_oe_nxt = 1'b0;
          w_ack_nxt    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
          w_tries_nxt  = 2'd0;
`endif
        end
      end

      // Data goes low one cycle before the clock is released: that is the start bit.
      INHIBIT: begin
        w_cnt_nxt = r_cnt + c_one;
        if (r_cnt == c_inh_start) w_dat_oe_nxt = 1'b1;
        if (r_cnt == c_inh_last) begin
          w_state_nxt  = SEND;
          w_clk_oe_nxt = 1'b0;
          w_dat_oe_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_bit_nxt    = 4'd0;
        end
      end

      SEND: begin
        if (w_clk_fall) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit + 4'd1;
          if (r_bit < 4'd8)            w_dat_oe_nxt = ~r_data[r_bit[2:0]];
          else if (r_bit == 4'd8)      w_dat_oe_nxt = ~r_par;
          else if (r_bit == 4'd9)      w_dat_oe_nxt = 1'b0;
          else if (r_bit == c_ack_edge) begin
            w_end     = 1'b1;
            w_end_ack = ~w_dat_sync;
          end
        end else if (r_cnt == c_tmo_last) begin
          w_end     = 1'b1;
          w_end_ack = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
      end
    endcase

    if (w_end) begin
      if (w_end_ack || !w_can_retry) begin
        w_state_nxt  = IDLE;
        w_done_nxt   = 1'b1;
        w_ack_nxt    = w_end_ack;
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
      end else begin
        w_state_nxt  = INHIBIT;
        w_cnt_nxt    = '0;
        w_clk_oe_nxt = 1'b1;
        w_dat_oe_nxt = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        w_tries_nxt  = r_tries + 2'd1;
`endif
      end
    end
  end

  assign cmd.ready  = (r_state == IDLE);
  assign cmd.busy   = (r_state != IDLE);
  assign cmd.done   = r_done;
  assign cmd.ack_ok = r_ack;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule
`default_nettype wire
